fetch_align_unit: RTL and testbench
===================================

FETCH_ALIGN_UNIT -- requirements
Module: fetch_align_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width.
REQ-002 SHALL have parameter RESET_PC, default 'h100, fetch/PC value after reset.
REQ-003 SHALL have parameter HQ_DEPTH, default 8, halfword queue entries; power of 2, >=4.
REQ-004 SHALL have parameter IM_AW, default 12, instruction-memory word-address width.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port o_imem_req  out  1  read request to synchronous 32-bit instruction memory.
REQ-008 SHALL have port o_imem_addr  out  IM_AW  word address, fetch PC bits [IM_AW+1:2].
REQ-009 SHALL have port i_imem_rdata  in  32  read data, valid exactly one cycle after accepted request.
REQ-010 SHALL have port i_redirect  in  1  branch/jump taken in EX.
REQ-011 SHALL have port i_redirect_target  in  XLEN  new PC; bit 0 ignored.
REQ-012 SHALL have port o_valid  out  1  instruction presented to ID.
REQ-013 SHALL have port i_id_ready  in  1  ID accepts; transfer when o_valid && i_id_ready.
REQ-014 SHALL have port o_instr  out  32  instruction; compressed form zero-extended to 32 bits.
REQ-015 SHALL have port o_pc  out  XLEN  PC of o_instr, halfword aligned.
REQ-016 SHALL have port o_is_compressed  out  1  o_instr[1:0] != 2'b11.

Function
REQ-017 SHALL hold word-aligned fetch PC fpc, halfword queue (HQ_DEPTH x 16), occupancy count, one in-flight flag, skip_lo flag, head PC.
REQ-018 SHALL assert o_imem_req when ~i_redirect and count + 2*inflight + 2 <= HQ_DEPTH; fpc += 4 per request.
REQ-019 SHALL set inflight the cycle after a request; response pushes rdata[15:0] then rdata[31:16] (2 entries).
REQ-020 SHALL, if skip_lo set on response, push only rdata[31:16] (1 entry) and clear skip_lo.
REQ-021 SHALL present head: compressed if head[1:0] != 2'b11, needing count >= 1; else 32-bit, needing count >= 2, o_instr = {entry1, entry0}.
REQ-022 SHALL drive o_valid = instruction complete at head && ~i_redirect; o_instr/o_pc don't-care when o_valid=0.
REQ-023 SHALL on transfer pop 1 (compressed) or 2 entries and advance head PC by 2 or 4.
REQ-024 SHALL support push and pop in same cycle; count updates by net amount; never overflows by REQ-018.
REQ-025 SHALL hold o_instr, o_pc, o_valid stable while o_valid && ~i_id_ready (no redirect).
REQ-026 SHALL on i_redirect, highest priority: empty queue, drop in-flight response next cycle, fpc <= {target[XLEN-1:2],2'b00}, skip_lo <= target[1], head PC <= {target[XLEN-1:1],1'b0}.
REQ-027 SHALL give redirect latency: redirect cycle N, request N+1, push N+2, o_valid at N+3.
REQ-028 SHALL handle a 32-bit instruction straddling two words: o_valid waits for second response.
REQ-029 SHALL wrap queue pointers modulo HQ_DEPTH and fpc modulo 2^XLEN without error.
REQ-030 SHALL treat back-to-back redirects: last one wins, all earlier in-flight data discarded.

Reset
REQ-031 SHALL on rst_n low asynchronously set fpc=RESET_PC, head PC=RESET_PC, count=0, inflight=0, skip_lo=0, o_valid=0.
REQ-032 SHALL drive o_imem_req=0 while in reset; first request, address RESET_PC>>2, in first cycle after release.
REQ-033 SHALL treat reset mid-operation as discarding queue and in-flight data.

Verification
REQ-034 SHALL cover: reset release, memory returns 32-bit words, i_id_ready=1 -> o_pc 0x100,0x104,0x108 on successive transfers, o_is_compressed=0.
REQ-035 SHALL cover: word 0x4501_4505 (two compressed) -> o_instr 0x4505 @0x100 then 0x4501 @0x102, both o_is_compressed=1.
REQ-036 SHALL cover: compressed at 0x100 then 32-bit at 0x102 spanning words -> second o_instr assembled from both, o_pc 0x102.
REQ-037 SHALL cover: redirect to 0x206 -> lower half of word 0x204 skipped, first o_pc=0x206 exactly 3 cycles later, no stale instruction.
REQ-038 SHALL cover: i_id_ready=0 for 20 cycles -> count saturates at HQ_DEPTH, o_imem_req deasserts, no entry lost on release.

Source files
------------

// File: rtl/fetch_align_unit.sv
// fetch_align_unit: fetches 32-bit words into a halfword queue and presents aligned
// 16/32-bit instructions with their PC to decode; redirects flush and refetch.
module fetch_align_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h100,
  parameter int HQ_DEPTH = 8,
  parameter int IM_AW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_imem_req,
  output logic [IM_AW-1:0] o_imem_addr,
  input  logic [31:0]      i_imem_rdata,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_target,
  output logic             o_valid,
  input  logic             i_id_ready,
  output logic [31:0]      o_instr,
  output logic [XLEN-1:0]  o_pc,
  output logic             o_is_compressed
);
  localparam int PW = $clog2(HQ_DEPTH);
  localparam int CW = PW + 2;

  logic [XLEN-1:0] fpc, head_pc;
  logic [15:0]     hq [HQ_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            inflight, skip_lo;
  logic [15:0]     e0, e1;
  logic            is_c, complete, xfer, push;
  logic [1:0]      n_push, n_pop;
  logic [CW-1:0]   need;

  assign e0 = hq[rd_ptr];
  assign e1 = hq[rd_ptr + PW'(1)];
  assign is_c = e0[1:0] != 2'b11;
  assign complete = is_c ? (count != '0) : (count >= (PW+1)'(2));
  assign o_valid = complete && !i_redirect;
  assign xfer = o_valid && i_id_ready;
  assign n_pop = xfer ? (is_c ? 2'd1 : 2'd2) : 2'd0;
  // a response arriving in a redirect cycle belongs to the old stream and is dropped
  assign push = inflight && !i_redirect;
  assign n_push = push ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
  // reserve room for the outstanding response plus the one about to be requested
  assign need = CW'(count) + CW'({inflight, 1'b0}) + CW'(2);
  assign o_imem_req = rst_n && !i_redirect && (need <= CW'(HQ_DEPTH));
  assign o_imem_addr = fpc[IM_AW+1:2];
  assign o_instr = is_c ? {16'h0, e0} : {e1, e0};
  assign o_pc = head_pc;
  assign o_is_compressed = is_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= RESET_PC;
      head_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      inflight <= 1'b0;
      skip_lo <= 1'b0;
    end else if (i_redirect) begin
      fpc <= i_redirect_target & ~XLEN'(3);
      head_pc <= i_redirect_target & ~XLEN'(1);
      skip_lo <= i_redirect_target[1];
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= o_imem_req;
      if (o_imem_req) fpc <= fpc + XLEN'(4);
      if (push) skip_lo <= 1'b0;
      count <= count + (PW+1)'(n_push) - (PW+1)'(n_pop);
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(n_pop);
      if (xfer) head_pc <= head_pc + (is_c ? XLEN'(2) : XLEN'(4));
    end
  end

  always_ff @(posedge clk) begin
    if (push && skip_lo) hq[wr_ptr] <= i_imem_rdata[31:16];
    else if (push) begin
      hq[wr_ptr] <= i_imem_rdata[15:0];
      hq[wr_ptr + PW'(1)] <= i_imem_rdata[31:16];
    end
  end
endmodule

// File: tb/tb_fetch_align_unit.sv
// tb_fetch_align_unit: random and directed fetch traffic checked against an
// instruction-stream model that decodes memory directly at the expected PC.
module tb_fetch_align_unit;
  localparam logic [63:0] RESET_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_imem_req;
  logic [11:0] o_imem_addr;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [63:0] i_redirect_target = '0;
  logic        o_valid;
  logic        i_id_ready = 1'b0;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_is_compressed;

  fetch_align_unit #(.XLEN(64), .RESET_PC(RESET_PC), .HQ_DEPTH(8), .IM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .i_redirect(i_redirect), .i_redirect_target(i_redirect_target),
    .o_valid(o_valid), .i_id_ready(i_id_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_is_compressed(o_is_compressed)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  always @(posedge clk) if (o_imem_req) i_imem_rdata <= mem[o_imem_addr];

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] exp_pc;
  int since;
  logic first_fits;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] hw(input logic [63:0] pc);
    logic [31:0] w;
    w = mem[pc[13:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] instr_at(input logic [63:0] pc);
    logic [15:0] h;
    h = hw(pc);
    return (h[1:0] != 2'b11) ? {16'h0, h} : {hw(pc + 64'd2), h};
  endfunction

  // the first instruction is available from the first word unless it is 32-bit at an odd halfword
  function automatic logic fits_first(input logic [63:0] pc);
    logic [15:0] h;
    h = hw(pc);
    return !pc[1] || (h[1:0] != 2'b11);
  endfunction

  task automatic step(input logic rdy, input logic redir, input logic [63:0] tgt);
    logic [31:0] ei;
    @(negedge clk);
    i_id_ready = rdy;
    i_redirect = redir;
    i_redirect_target = tgt;
    #1;
    since++;
    if (redir) begin
      chk("redir_valid_low", 64'(o_valid), 64'd0);
      chk("redir_req_low", 64'(o_imem_req), 64'd0);
      exp_pc = tgt & ~64'd1;
      since = 0;
      first_fits = fits_first(exp_pc);
    end else begin
      if (since == 1) chk("redir_req_addr", 64'({o_imem_req, o_imem_addr}), 64'({1'b1, exp_pc[13:2]}));
      if (since == 1 || since == 2) chk("lat_no_valid", 64'(o_valid), 64'd0);
      if (since == 3) chk("lat_first_valid", 64'(o_valid), 64'(first_fits));
      if (since == 4 && !first_fits) chk("straddle_valid", 64'(o_valid), 64'd1);
      if (o_valid) begin
        ei = instr_at(exp_pc);
        chk("pc", o_pc, exp_pc);
        chk("instr", 64'(o_instr), 64'(ei));
        chk("is_c", 64'(o_is_compressed), 64'(ei[1:0] != 2'b11));
        if (rdy) exp_pc += (ei[1:0] != 2'b11) ? 64'd2 : 64'd4;
      end
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    i_redirect = 1'b0;
    i_id_ready = 1'b0;
    #1;
    chk("rst_req", 64'(o_imem_req), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    repeat (2) @(negedge clk);
    #1 chk("rst_req_hold", 64'(o_imem_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", 64'({o_imem_req, o_imem_addr}), 64'({1'b1, RESET_PC[13:2]}));
    chk("rel_valid", 64'(o_valid), 64'd0);
    exp_pc = RESET_PC;
    since = 1;
    first_fits = fits_first(RESET_PC);
  endtask

  task automatic run(input int n, input int rdy_pct, input int redir_pm);
    logic [63:0] t;
    for (int i = 0; i < n; i++) begin
      t = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 16383));
      step($urandom_range(0, 99) < rdy_pct, $urandom_range(0, 999) < redir_pm, t);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom | 32'h3;
    do_reset();
    repeat (10) step(1'b1, 1'b0, '0);
    mem[64] = 32'h4501_4505;
    do_reset();
    repeat (6) step(1'b1, 1'b0, '0);
    mem[64] = 32'h0513_4505;
    mem[65] = 32'h1234_0093;
    do_reset();
    repeat (6) step(1'b1, 1'b0, '0);
    mem[129] = 32'h4501_ffff;
    step(1'b1, 1'b1, 64'h206);
    repeat (6) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 64'hffff_ffff_ffff_fffc);
    repeat (8) step(1'b1, 1'b0, '0);
    repeat (20) step(1'b0, 1'b0, '0);
    chk("stall_req_off", 64'(o_imem_req), 64'd0);
    chk("stall_valid", 64'(o_valid), 64'd1);
    repeat (30) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 64'h300);
    step(1'b1, 1'b1, 64'h402);
    step(1'b0, 1'b1, 64'h10b);
    repeat (10) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    do_reset();
    run(1500, 70, 20);
    do_reset();
    run(1500, 50, 40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
